brick_field: RTL

- Brick-wall stage beside the ball mover.
- Holds the alive bitmap of a NROWS x NCOLS brick grid and checks the ball's bounding box against every live brick once per movement tick.
- On a hit it clears that brick, bumps the score and pulses a reflect request back to the ball mover.
- In parallel it renders brick pixels from the VGA scan coordinates for the downstream colour mux.

---
 rtl/brick_field.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/brick_field.sv
// Brick wall: alive bitmap, one-brick-per-cycle ball collision scan, scoring and brick pixel render.
// Scan latency idx+2 cycles to the hit pulse (full miss: NROWS*NCOLS busy cycles); render latency 1 cycle.
module brick_field #(
  parameter int NCOLS     = 10,
  parameter int NROWS     = 4,
  parameter int BRICK_W   = 64,
  parameter int BRICK_H   = 16,
  parameter int TOP_Y     = 40,
  parameter int BALL_SIZE = 20,
  parameter int GAP       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scan_start,
  input  logic [9:0]  ball_x,
  input  logic [9:0]  ball_y,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        active_pixels,
  output logic        hit,
  output logic        bounce_x,
  output logic        bounce_y,
  output logic [5:0]  hit_index,
  output logic [7:0]  score,
  output logic        all_clear,
  output logic        busy,
  output logic        brick_pixel,
  output logic [23:0] brick_color
);

  localparam int NB = NROWS * NCOLS;
  localparam int CW = (NCOLS > 1) ? $clog2(NCOLS) : 1;
  localparam int RW = (NROWS > 2) ? $clog2(NROWS) : 2;
  localparam int XS = $clog2(BRICK_W);
  localparam int YS = $clog2(BRICK_H);
  localparam logic [CW-1:0] LAST_COL = CW'(NCOLS - 1);
  localparam logic [5:0]    LAST_IDX = 6'(NB - 1);

  typedef enum logic [1:0] {IDLE, SCAN, HIT} state_t;

  state_t          state_q, state_d;
  logic [NB-1:0]   alive_q, alive_d;
  logic [9:0]      bx_q, bx_d, by_q, by_d;
  logic [5:0]      idx_q, idx_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic            hit_q, hit_d;
  logic            bnx_q, bnx_d, bny_q, bny_d;
  logic [5:0]      hit_index_q, hit_index_d;
  logic [7:0]      score_q, score_d;
  logic            all_clear_q;
  logic            pix_q;
  logic [23:0]     color_q;

  // Geometry of the brick currently under test; 11-bit sums so nothing wraps.
  logic [10:0] bx11, by11, brick_x, brick_y;
  logic        overlap, side;

  assign bx11    = {1'b0, bx_q};
  assign by11    = {1'b0, by_q};
  assign brick_x = 11'(col_q) * 11'(BRICK_W);
  assign brick_y = 11'(TOP_Y) + 11'(row_q) * 11'(BRICK_H);

  assign overlap = alive_q[idx_q]
                && (bx11 < brick_x + 11'(BRICK_W))
                && (bx11 + 11'(BALL_SIZE) > brick_x)
                && (by11 < brick_y + 11'(BRICK_H))
                && (by11 + 11'(BALL_SIZE) > brick_y);

  assign side = (by11 + 11'(BALL_SIZE) > brick_y + 11'd2)
             && (by11 < brick_y + 11'(BRICK_H - 2));

  always_comb begin
    state_d     = state_q;
    alive_d     = alive_q;
    bx_d        = bx_q;
    by_d        = by_q;
    idx_d       = idx_q;
    col_d       = col_q;
    row_d       = row_q;
    hit_d       = 1'b0;
    bnx_d       = 1'b0;
    bny_d       = 1'b0;
    hit_index_d = hit_index_q;
    score_d     = score_q;
    case (state_q)
      IDLE: begin
        if (scan_start) begin
          bx_d    = ball_x;
          by_d    = ball_y;
          idx_d   = '0;
          col_d   = '0;
          row_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        // idx/row/col stay put on overlap so HIT still addresses the same brick.
        if (overlap) begin
          state_d = HIT;
        end else if (idx_q == LAST_IDX) begin
          state_d = IDLE;
        end else begin
          idx_d = idx_q + 6'd1;
          if (col_q == LAST_COL) begin
            col_d = '0;
            row_d = row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      HIT: begin
        alive_d[idx_q] = 1'b0;
        hit_d          = 1'b1;
        hit_index_d    = idx_q;
        bnx_d          = side;
        bny_d          = !side;
        if (score_q != 8'hFF) score_d = score_q + 8'd1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      alive_q     <= '1;
      bx_q        <= '0;
      by_q        <= '0;
      idx_q       <= '0;
      col_q       <= '0;
      row_q       <= '0;
      hit_q       <= 1'b0;
      bnx_q       <= 1'b0;
      bny_q       <= 1'b0;
      hit_index_q <= '0;
      score_q     <= '0;
      all_clear_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      alive_q     <= alive_d;
      bx_q        <= bx_d;
      by_q        <= by_d;
      idx_q       <= idx_d;
      col_q       <= col_d;
      row_q       <= row_d;
      hit_q       <= hit_d;
      bnx_q       <= bnx_d;
      bny_q       <= bny_d;
      hit_index_q <= hit_index_d;
      score_q     <= score_d;
      all_clear_q <= (alive_q == '0);
    end
  end

  // Render path: map scan coordinates to a brick cell and its face area.
  logic [10:0] yrel, prow;
  logic [9:0]  pcol;
  logic [5:0]  pidx;
  logic        in_grid, face, pix;
  logic [23:0] row_color;

  assign yrel    = {1'b0, y} - 11'(TOP_Y);
  assign prow    = yrel >> YS;
  assign pcol    = x >> XS;
  assign in_grid = ({1'b0, y} >= 11'(TOP_Y)) && (prow < 11'(NROWS)) && (pcol < 10'(NCOLS));
  assign pidx    = 6'(prow[RW-1:0]) * 6'(NCOLS) + 6'(pcol[CW-1:0]);
  assign face    = (x[XS-1:0] < XS'(BRICK_W - GAP)) && (yrel[YS-1:0] < YS'(BRICK_H - GAP));
  assign pix     = active_pixels && in_grid && alive_q[pidx] && face;

  always_comb begin
    case (prow[1:0])
      2'd0:    row_color = 24'hFF0000;
      2'd1:    row_color = 24'hFF8000;
      2'd2:    row_color = 24'hFFFF00;
      default: row_color = 24'h00FF00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pix_q   <= 1'b0;
      color_q <= '0;
    end else begin
      pix_q   <= pix;
      color_q <= pix ? row_color : 24'h000000;
    end
  end

  assign hit         = hit_q;
  assign bounce_x    = bnx_q;
  assign bounce_y    = bny_q;
  assign hit_index   = hit_index_q;
  assign score       = score_q;
  assign all_clear   = all_clear_q;
  assign busy        = (state_q != IDLE);
  assign brick_pixel = pix_q;
  assign brick_color = color_q;

endmodule
